// File: rtl/general_clock_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : general_clock_divider_pkg
//  Description : Shared types and helpers for the programmable clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package general_clock_divider_pkg;

    typedef enum logic [0:0] {
        MODE_IDLE = 1'b0,
        MODE_RUN  = 1'b1
    } div_mode_e;

    // Smallest divisor that produces a clock; 0 and 1 park the output low.
    localparam int unsigned c_MIN_DIV = 2;

    function automatic div_mode_e mode_of(input logic [31:0] div);
        return (div >= c_MIN_DIV) ? MODE_RUN : MODE_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/general_clock_divider_mod_n_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_counter
//  Description : Counts 0..N-1 with terminal-count flag and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_modulus,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_last;

    assign w_last  = i_modulus - WIDTH'(1);
    assign o_tc    = i_en && (r_count == w_last);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/general_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : general_clock_divider
//  Description : Programmable integer clock divider with registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module general_clock_divider
    import general_clock_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en_n,
    input  logic [WIDTH-1:0] data_in,
    output logic             clk_out
);

    logic [WIDTH-1:0] r_div_pend;
    logic [WIDTH-1:0] r_div_act;
    logic             r_clk_out;

    logic [WIDTH-1:0] w_cnt;
    logic             w_tc;
    div_mode_e        w_mode;
    div_mode_e        w_pend_mode;
    logic [WIDTH:0]   w_half;
    logic [WIDTH:0]   w_cnt_inc;
    logic [WIDTH-1:0] w_div_act_nxt;
    logic             w_clk_out_nxt;

    assign w_mode      = mode_of(32'(r_div_act));
    assign w_pend_mode = mode_of(32'(r_div_pend));

    // One extra bit so that ceil(N/2) stays correct for the largest divisor.
    assign w_half    = ({1'b0, r_div_act} + (WIDTH+1)'(1)) >> 1;
    assign w_cnt_inc = {1'b0, w_cnt} + (WIDTH+1)'(1);

    mod_n_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_mode == MODE_IDLE),
        .i_en      (w_mode == MODE_RUN),
        .i_modulus (r_div_act),
        .o_count   (w_cnt),
        .o_tc      (w_tc)
    );

    always_comb begin
        w_div_act_nxt = r_div_act;
        w_clk_out_nxt = 1'b0;
        case (w_mode)
            MODE_IDLE: begin
                if (w_pend_mode == MODE_RUN) begin
                    w_div_act_nxt = r_div_pend;
                    w_clk_out_nxt = 1'b1;
                end
            end
            MODE_RUN: begin
                // The pending divisor is only adopted at a period boundary.
                if (w_tc) begin
                    w_div_act_nxt = r_div_pend;
                    w_clk_out_nxt = (w_pend_mode == MODE_RUN);
                end else begin
                    w_clk_out_nxt = (w_cnt_inc < w_half);
                end
            end
            default: begin
                w_div_act_nxt = r_div_act;
                w_clk_out_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_pend <= '0;
            r_div_act  <= '0;
            r_clk_out  <= 1'b0;
        end else begin
            if (!ld_en_n) begin
                r_div_pend <= data_in;
            end
            r_div_act <= w_div_act_nxt;
            r_clk_out <= w_clk_out_nxt;
        end
    end

    assign clk_out = r_clk_out;

endmodule
`default_nettype wire

// File: tb/tb_general_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_general_clock_divider
//  Description : Directed scoreboard bench for the programmable clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_general_clock_divider;

    logic       clk;
    logic       rst;
    logic       ld_en_n;
    logic [3:0] data_in;
    logic       clk_out;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];

    general_clock_divider #(
        .WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_en_n (ld_en_n),
        .data_in (data_in),
        .clk_out (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of inputs, queue the expected output, compare after the edge.
    task automatic cyc(input logic r, input logic ld_n, input logic [3:0] d,
                       input logic exp_v, input string tag);
        logic want;
        rst     = r;
        ld_en_n = ld_n;
        data_in = d;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        checks++;
        assert (clk_out === want) else begin
            failures++;
            $error("FAIL %s: clk_out=%b expected=%b (check %0d)", tag, clk_out, want, checks);
        end
    endtask

    task automatic run(input int hi, input int lo, input int reps,
                       input logic ld_n, input logic [3:0] d, input string tag);
        for (int p = 0; p < reps; p++) begin
            for (int i = 0; i < hi; i++) cyc(1'b0, ld_n, d, 1'b1, tag);
            for (int i = 0; i < lo; i++) cyc(1'b0, ld_n, d, 1'b0, tag);
        end
    endtask

    initial begin
        rst     = 1'b1;
        ld_en_n = 1'b1;
        data_in = 4'd0;

        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'd0, 1'b0, "reset");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd0, 1'b0, "idle_after_reset");

        // N=3 with the load strobe held low throughout
        cyc(1'b0, 1'b0, 4'd3, 1'b0, "load3_e0");
        run(2, 1, 3, 1'b0, 4'd3, "div3_hold");

        // Load on a boundary edge: the old divisor (3) governs this period
        cyc(1'b0, 1'b0, 4'd4, 1'b1, "load4_at_boundary");
        cyc(1'b0, 1'b1, 4'd0, 1'b1, "div3_tail");
        cyc(1'b0, 1'b1, 4'd0, 1'b0, "div3_tail");
        run(2, 2, 1, 1'b1, 4'd0, "div4");

        // Load 6 mid-period of a 4-cycle period
        cyc(1'b0, 1'b1, 4'd0, 1'b1, "div4_start");
        cyc(1'b0, 1'b0, 4'd6, 1'b1, "load6_mid");
        cyc(1'b0, 1'b1, 4'd0, 1'b0, "div4_finish");
        cyc(1'b0, 1'b1, 4'd0, 1'b0, "div4_finish");
        run(3, 3, 2, 1'b1, 4'd0, "div6");

        // Disable with 1 mid-period; the current period completes
        cyc(1'b0, 1'b1, 4'd0, 1'b1, "div6_start");
        cyc(1'b0, 1'b0, 4'd1, 1'b1, "load1_mid");
        cyc(1'b0, 1'b1, 4'd0, 1'b1, "div6_finish");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'd0, 1'b0, "div6_finish");
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 4'd0, 1'b0, "disabled");

        // Reload 2 from idle
        cyc(1'b0, 1'b0, 4'd2, 1'b0, "load2_e0");
        run(1, 1, 3, 1'b1, 4'd0, "div2");

        // Maximum divisor
        cyc(1'b0, 1'b1, 4'd0, 1'b1, "div2_start");
        cyc(1'b0, 1'b0, 4'd15, 1'b0, "load15");
        run(8, 7, 1, 1'b1, 4'd0, "div15");

        // Load 5 on the boundary edge: another full 15-cycle period first
        cyc(1'b0, 1'b0, 4'd5, 1'b1, "load5_at_boundary");
        run(7, 7, 1, 1'b1, 4'd0, "div15_second");
        run(3, 2, 1, 1'b1, 4'd0, "div5");

        // Reset in the middle of the high phase
        cyc(1'b0, 1'b1, 4'd0, 1'b1, "div5_high");
        cyc(1'b0, 1'b1, 4'd0, 1'b1, "div5_high");
        cyc(1'b1, 1'b1, 4'd0, 1'b0, "reset_mid_high");
        cyc(1'b1, 1'b1, 4'd0, 1'b0, "reset_hold");
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 4'd0, 1'b0, "idle_after_mid_reset");

        cyc(1'b0, 1'b0, 4'd4, 1'b0, "reload4_e0");
        run(2, 2, 2, 1'b1, 4'd0, "div4_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
